// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: one femto bus channel carrying request fields one way and response/fault the other
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic w_rb;
  logic [ACC_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] wdata;
  logic req;
  logic [DATA_WIDTH-1:0] rdata;
  logic resp;
  logic fault;
  modport master (output addr, w_rb, acc, wdata, req, input rdata, resp, fault);
  modport slave (input addr, w_rb, acc, wdata, req, output rdata, resp, fault);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with one-deep request buffers, one transaction in flight.
// Optional BUS_ARB_TIMEOUT_EN: fault the owner after TIMEOUT_CYCLES silent WAIT cycles.
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  bus_arbiter_if.slave m0,
  bus_arbiter_if.slave m1,
  bus_arbiter_if.master s
);
  localparam int SW = ADDR_WIDTH + 1 + ACC_WIDTH + DATA_WIDTH;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [1:0] pending, req, busy, accept, drop;
  logic last_grant, owner, winner, grant, done_ok, done_fault, tmo;
  logic [SW-1:0] slot [2];
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1) && !s.resp && !s.fault;
  // WAIT-cycle counter, restarted on every grant
  always_ff @(posedge clk) cnt <= (rst || grant) ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
`else
  logic unused_timeout;
  assign tmo = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
  assign req = {m1.req, m0.req};
  assign busy = pending | (state == WAIT ? 2'b01 << owner : 2'b00);
  assign accept = req & ~busy;
  assign drop = req & busy;
  assign winner = &pending ? ~last_grant : pending[1];
  assign grant = state == IDLE && |pending;
  assign done_fault = state == WAIT && (s.fault || tmo);
  assign done_ok = state == WAIT && s.resp && !s.fault;
  assign m0.resp = done_ok && !owner;
  assign m1.resp = done_ok && owner;
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  // Request slots; only read once their pending bit is set, so no reset needed
  always_ff @(posedge clk) begin
    if (accept[0]) slot[0] <= {m0.addr, m0.w_rb, m0.acc, m0.wdata};
    if (accept[1]) slot[1] <= {m1.addr, m1.w_rb, m1.acc, m1.wdata};
  end
  // Arbitration FSM with registered slave request and fault pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      last_grant <= 1'b1;
      owner <= 1'b0;
      s.req <= 1'b0;
      s.addr <= '0;
      s.w_rb <= 1'b0;
      s.acc <= '0;
      s.wdata <= '0;
      m0.fault <= 1'b0;
      m1.fault <= 1'b0;
    end else begin
      pending <= (pending & ~(grant ? 2'b01 << winner : 2'b00)) | accept;
      s.req <= grant;
      m0.fault <= drop[0] || (done_fault && !owner);
      m1.fault <= drop[1] || (done_fault && owner);
      if (grant) begin
        state <= WAIT;
        owner <= winner;
        {s.addr, s.w_rb, s.acc, s.wdata} <= slot[winner];
      end else if (done_ok || done_fault) begin
        state <= IDLE;
        last_grant <= owner;
      end
    end
  end
endmodule
